// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the dual-master data memory arbiter: FSM encoding,
// master indices and default bus widths.
package dmem_arb_pkg;

   localparam int ADDR_W_DEF = 18;
   localparam int DATA_W_DEF = 32;

   localparam logic MST0 = 1'b0;
   localparam logic MST1 = 1'b1;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } state_t;

endpackage

// File: rtl/dmem_arb_rr_arb2.sv
// Two-way round-robin picker; remembers the last granted master and favours
// the other one on a tie. Pointer moves only when a pick is taken.
module rr_arb2
   import dmem_arb_pkg::*;
(
   input  logic       clk,
   input  logic       i_rst_n,
   input  logic [1:0] i_req,
   input  logic       i_take,
   output logic       o_any,
   output logic       o_win
);

   logic r_last;

   always_comb begin
      o_any = |i_req;
      if (i_req == 2'b11) begin
         o_win = ~r_last;
      end else begin
         o_win = i_req[1] ? MST1 : MST0;
      end
   end

   // Starting with MST1 as "last" hands the first tie to master 0.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_last <= MST1;
      end else if (i_take && o_any) begin
         r_last <= o_win;
      end
   end

endmodule

// File: rtl/dmem_arb.sv
// Dual-master (CPU / DMA) data memory arbiter, one access every two cycles.
// Optional macro DMEM_ARB_ALIGN_CHK_EN suppresses misaligned accesses and adds err.
module dmem_arb
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m0_gnt,
   output logic              m1_gnt,
   output logic              m0_rvalid,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_ena,
   output logic              mem_rw,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_ALIGN_CHK_EN
   ,
   output logic              err
`endif
);

   state_t            r_state;
   state_t            w_next;
   logic              w_any;
   logic              w_win;
   logic              w_take;
   logic              w_bad;
   logic              w_rd_issue;
   logic              r_win;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_rv0;
   logic              r_rv1;
   logic [DATA_W-1:0] r_rdata;

   rr_arb2 u_arb (
      .clk     (clk),
      .i_rst_n (rst),
      .i_req   ({m1_req, m0_req}),
      .i_take  (w_take),
      .o_any   (w_any),
      .o_win   (w_win)
   );

`ifdef DMEM_ARB_ALIGN_CHK_EN
   assign w_bad = |r_addr[1:0];
   assign err   = (r_state == ST_ISSUE) && w_bad;
`else
   assign w_bad = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next  = r_state;
      w_take  = 1'b0;
      m0_gnt  = 1'b0;
      m1_gnt  = 1'b0;
      mem_ena = 1'b0;
      mem_rw  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_any) begin
               w_next = ST_ISSUE;
               w_take = 1'b1;
            end
         end
         ST_ISSUE: begin
            w_next  = ST_IDLE;
            m0_gnt  = (r_win == MST0);
            m1_gnt  = (r_win == MST1);
            mem_ena = ~w_bad;
            mem_rw  = r_we & ~w_bad;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // The memory port sees only the latched request, never the live master buses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_win   <= MST0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
      end else if (w_take) begin
         r_win   <= w_win;
         r_we    <= (w_win == MST1) ? m1_we    : m0_we;
         r_addr  <= (w_win == MST1) ? m1_addr  : m0_addr;
         r_wdata <= (w_win == MST1) ? m1_wdata : m0_wdata;
      end
   end

   assign w_rd_issue = (r_state == ST_ISSUE) && !r_we && !w_bad;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rv0   <= 1'b0;
         r_rv1   <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_rv0 <= w_rd_issue && (r_win == MST0);
         r_rv1 <= w_rd_issue && (r_win == MST1);
         if (w_rd_issue) begin
            r_rdata <= mem_rdata;
         end
      end
   end

   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign rdata     = r_rdata;
   assign m0_rvalid = r_rv0;
   assign m1_rvalid = r_rv1;

endmodule

// File: tb/tb_dmem_arb.sv
// Bench for dmem_arb: directed scenarios plus randomized two-master traffic
// scored against a transaction-level arbitration and memory model.
module tb_dmem_arb;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [17:0] m0_addr, m1_addr;
   logic [31:0] m0_wdata, m1_wdata;
   logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
   logic [31:0] rdata;
   logic        mem_ena, mem_rw;
   logic [17:0] mem_addr;
   logic [31:0] mem_wdata, mem_rdata;
`ifdef DMEM_ARB_ALIGN_CHK_EN
   logic        err;
`endif

   int n_chk = 0;
   int n_err = 0;

   logic [31:0] mem [0:65535];
   logic        pre_en = 1'b0;
   logic [15:0] pre_idx = '0;
   logic [31:0] pre_val = '0;

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr[17:2]];
   always @(posedge clk) begin
      if (pre_en) mem[pre_idx] <= pre_val;
      else if (mem_ena && mem_rw) mem[mem_addr[17:2]] <= mem_wdata;
   end

   dmem_arb dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
      .rdata(rdata), .mem_ena(mem_ena), .mem_rw(mem_rw), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_ALIGN_CHK_EN
      , .err(err)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic poke(input logic [15:0] idx, input logic [31:0] v);
      pre_idx = idx;
      pre_val = v;
      pre_en  = 1'b1;
      step();
      pre_en  = 1'b0;
   endtask

   task automatic do_reset();
      m0_req = 1'b0;
      m1_req = 1'b0;
      rst = 1'b0;
      step();
      rst = 1'b1;
      step();
   endtask

   task automatic test_reset();
      #3;
      n_chk++; if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_ena, mem_rw} !== 6'b0) begin n_err++; $display("FAIL rst_ctrl: got %b want 000000", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_ena, mem_rw}); end
      n_chk++; if (mem_addr !== 18'h0) begin n_err++; $display("FAIL rst_addr: got %h want 0", mem_addr); end
      n_chk++; if (mem_wdata !== 32'h0) begin n_err++; $display("FAIL rst_wdata: got %h want 0", mem_wdata); end
      n_chk++; if (rdata !== 32'h0) begin n_err++; $display("FAIL rst_rdata: got %h want 0", rdata); end
`ifdef DMEM_ARB_ALIGN_CHK_EN
      n_chk++; if (err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", err); end
`endif
      @(posedge clk); #1;
      rst = 1'b1;
      step();
      n_chk++; if ({m0_gnt, m1_gnt, mem_ena} !== 3'b0) begin n_err++; $display("FAIL rst_idle: got %b want 000", {m0_gnt, m1_gnt, mem_ena}); end
   endtask

   task automatic test_single_write();
      m0_req = 1'b1; m0_we = 1'b1; m0_addr = 18'h00010; m0_wdata = 32'hDEADBEEF;
      step();
      n_chk++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin n_err++; $display("FAIL wr_gnt: got %b%b want 10", m0_gnt, m1_gnt); end
      n_chk++; if (mem_ena !== 1'b1 || mem_rw !== 1'b1) begin n_err++; $display("FAIL wr_strobe: got %b%b want 11", mem_ena, mem_rw); end
      n_chk++; if (mem_addr !== 18'h00010) begin n_err++; $display("FAIL wr_addr: got %h want 00010", mem_addr); end
      n_chk++; if (mem_wdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr_wdata: got %h want deadbeef", mem_wdata); end
      m0_req = 1'b0;
      step();
      n_chk++; if (m0_gnt !== 1'b0 || mem_ena !== 1'b0 || m0_rvalid !== 1'b0) begin n_err++; $display("FAIL wr_pulse: got gnt=%b ena=%b rv=%b want 000", m0_gnt, mem_ena, m0_rvalid); end
      n_chk++; if (mem[4] !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr_commit: got %h want deadbeef", mem[4]); end
      m0_req = 1'b1; m0_we = 1'b0;
      step();
      n_chk++; if (m0_gnt !== 1'b1 || mem_rw !== 1'b0) begin n_err++; $display("FAIL rd_gnt: got gnt=%b rw=%b want 1 0", m0_gnt, mem_rw); end
      m0_req = 1'b0;
      step();
      n_chk++; if (m0_rvalid !== 1'b1 || m1_rvalid !== 1'b0) begin n_err++; $display("FAIL rd_rvalid: got %b%b want 10", m0_rvalid, m1_rvalid); end
      n_chk++; if (rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_data: got %h want deadbeef", rdata); end
      step();
      n_chk++; if (m0_rvalid !== 1'b0 || rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_hold: got rv=%b data=%h want 0 deadbeef", m0_rvalid, rdata); end
   endtask

   task automatic test_contention();
      int got[$];
      int at[$];
      int c0, c1;
      c0 = 0; c1 = 0;
      do_reset();
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 18'h00010;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 18'h00020;
      for (int t = 0; t < 24 && got.size() < 8; t++) begin
         step();
         if (m0_gnt) begin got.push_back(0); at.push_back(t); c0++; if (c0 == 4) m0_req = 1'b0; end
         if (m1_gnt) begin got.push_back(1); at.push_back(t); c1++; if (c1 == 4) m1_req = 1'b0; end
      end
      n_chk++; if (got.size() != 8) begin n_err++; $display("FAIL cont_count: got %0d grants want 8", got.size()); end
      for (int i = 0; i < got.size(); i++) begin
         n_chk++; if (got[i] != i % 2) begin n_err++; $display("FAIL cont_order[%0d]: got m%0d want m%0d", i, got[i], i % 2); end
         n_chk++; if (at[i] != 2 * i) begin n_err++; $display("FAIL cont_cycle[%0d]: got %0d want %0d", i, at[i], 2 * i); end
      end
      m0_req = 1'b0; m1_req = 1'b0;
      step(); step();
   endtask

   task automatic test_read_latency();
      poke(16'hFFFF, 32'h12345678);
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 18'h3FFFC;
      n_chk++; if (m1_rvalid !== 1'b0) begin n_err++; $display("FAIL lat_c1: got rv=%b want 0", m1_rvalid); end
      step();
      n_chk++; if (m1_gnt !== 1'b1 || m1_rvalid !== 1'b0) begin n_err++; $display("FAIL lat_c2: got gnt=%b rv=%b want 1 0", m1_gnt, m1_rvalid); end
      m1_req = 1'b0;
      step();
      n_chk++; if (m1_rvalid !== 1'b1 || m0_rvalid !== 1'b0) begin n_err++; $display("FAIL lat_c3: got m1rv=%b m0rv=%b want 1 0", m1_rvalid, m0_rvalid); end
      n_chk++; if (rdata !== 32'h12345678) begin n_err++; $display("FAIL lat_data: got %h want 12345678", rdata); end
      step();
      n_chk++; if (m1_rvalid !== 1'b0 || m0_rvalid !== 1'b0) begin n_err++; $display("FAIL lat_c4: got %b%b want 00", m1_rvalid, m0_rvalid); end
   endtask

   task automatic test_late_request();
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 18'h00010;
      step();
      n_chk++; if (m0_gnt !== 1'b1) begin n_err++; $display("FAIL late_m0: got %b want 1", m0_gnt); end
      m0_req = 1'b0;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 18'h00020;
      step();
      n_chk++; if (m1_gnt !== 1'b0 || mem_ena !== 1'b0) begin n_err++; $display("FAIL late_idle: got gnt=%b ena=%b want 0 0", m1_gnt, mem_ena); end
      step();
      n_chk++; if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0) begin n_err++; $display("FAIL late_m1: got %b%b want 10", m1_gnt, m0_gnt); end
      m1_req = 1'b0;
      step(); step();
   endtask

   task automatic test_reset_mid_issue();
      poke(16'd8, 32'h0BADF00D);
      m0_req = 1'b1; m0_we = 1'b1; m0_addr = 18'h00020; m0_wdata = 32'hCAFEF00D;
      step();
      n_chk++; if (m0_gnt !== 1'b1) begin n_err++; $display("FAIL rmi_gnt: got %b want 1", m0_gnt); end
      #2;
      rst = 1'b0;
      m0_req = 1'b0;
      #1;
      n_chk++; if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_ena, mem_rw} !== 6'b0) begin n_err++; $display("FAIL rmi_ctrl: got %b want 000000", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_ena, mem_rw}); end
      n_chk++; if (mem_addr !== 18'h0 || mem_wdata !== 32'h0 || rdata !== 32'h0) begin n_err++; $display("FAIL rmi_data: got addr=%h wd=%h rd=%h want 0 0 0", mem_addr, mem_wdata, rdata); end
      @(posedge clk); #1;
      rst = 1'b1;
      step(); step();
      n_chk++; if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid} !== 4'b0) begin n_err++; $display("FAIL rmi_after: got %b want 0000", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}); end
      n_chk++; if (mem[8] !== 32'h0BADF00D) begin n_err++; $display("FAIL rmi_mem: got %h want 0badf00d", mem[8]); end
   endtask

`ifdef DMEM_ARB_ALIGN_CHK_EN
   task automatic test_align_err();
      poke(16'd4, 32'hDEADBEEF);
      m0_req = 1'b1; m0_we = 1'b1; m0_addr = 18'h00011; m0_wdata = 32'h5A5A5A5A;
      step();
      n_chk++; if (m0_gnt !== 1'b1 || err !== 1'b1) begin n_err++; $display("FAIL al_pulse: got gnt=%b err=%b want 1 1", m0_gnt, err); end
      n_chk++; if (mem_ena !== 1'b0 || mem_rw !== 1'b0) begin n_err++; $display("FAIL al_ena: got %b%b want 00", mem_ena, mem_rw); end
      m0_we = 1'b0; m0_addr = 18'h00012;
      step();
      n_chk++; if (err !== 1'b0 || mem[4] !== 32'hDEADBEEF) begin n_err++; $display("FAIL al_mem: got err=%b mem=%h want 0 deadbeef", err, mem[4]); end
      step();
      n_chk++; if (m0_gnt !== 1'b1 || err !== 1'b1) begin n_err++; $display("FAIL al_rd: got gnt=%b err=%b want 1 1", m0_gnt, err); end
      m0_req = 1'b0;
      step();
      n_chk++; if (m0_rvalid !== 1'b0) begin n_err++; $display("FAIL al_rv: got %b want 0", m0_rvalid); end
   endtask
`else
   task automatic test_misaligned_pass();
      m0_req = 1'b1; m0_we = 1'b1; m0_addr = 18'h00011; m0_wdata = 32'h5A5A5A5A;
      step();
      n_chk++; if (mem_ena !== 1'b1 || mem_rw !== 1'b1 || mem_addr !== 18'h00011) begin n_err++; $display("FAIL mis_pass: got ena=%b rw=%b addr=%h want 1 1 00011", mem_ena, mem_rw, mem_addr); end
      m0_req = 1'b0;
      step();
      n_chk++; if (mem[4] !== 32'h5A5A5A5A) begin n_err++; $display("FAIL mis_mem: got %h want 5a5a5a5a", mem[4]); end
   endtask
`endif

   task automatic test_random();
      logic [31:0] ref_mem [0:15];
      logic        p [2];
      logic        w [2];
      logic [17:0] a [2];
      logic [31:0] d [2];
      logic        iss_v, iss_we, nxt_v;
      int          iss_who, nxt_who, last, idx;
      logic [31:0] iss_rd, exp_rd;
      do_reset();
      for (int i = 0; i < 16; i++) begin
         ref_mem[i] = $urandom;
         poke(16'(32'h40 + i), ref_mem[i]);
      end
      for (int m = 0; m < 2; m++) begin
         p[m] = 1'($urandom_range(1, 0));
         w[m] = 1'($urandom_range(1, 0));
         a[m] = 18'((32'h40 + $urandom_range(15, 0)) << 2);
         d[m] = $urandom;
      end
      iss_v = 1'b0; iss_we = 1'b0; iss_who = 0; iss_rd = '0; exp_rd = '0; last = 1;
      for (int c = 0; c < 400; c++) begin
         m0_req = p[0]; m0_we = w[0]; m0_addr = a[0]; m0_wdata = d[0];
         m1_req = p[1]; m1_we = w[1]; m1_addr = a[1]; m1_wdata = d[1];
         nxt_v   = !iss_v && (p[0] || p[1]);
         nxt_who = (p[0] && p[1]) ? 1 - last : (p[1] ? 1 : 0);
         step();
         if (iss_v && !iss_we) exp_rd = iss_rd;
         n_chk++; if (m0_rvalid !== (iss_v && !iss_we && iss_who == 0) || m1_rvalid !== (iss_v && !iss_we && iss_who == 1)) begin n_err++; $display("FAIL rnd_rvalid c=%0d: got %b%b want %b%b", c, m0_rvalid, m1_rvalid, iss_v && !iss_we && iss_who == 0, iss_v && !iss_we && iss_who == 1); end
         n_chk++; if (rdata !== exp_rd) begin n_err++; $display("FAIL rnd_rdata c=%0d: got %h want %h", c, rdata, exp_rd); end
         n_chk++; if (m0_gnt !== (nxt_v && nxt_who == 0) || m1_gnt !== (nxt_v && nxt_who == 1) || mem_ena !== nxt_v) begin n_err++; $display("FAIL rnd_gnt c=%0d: got g0=%b g1=%b ena=%b want %b %b %b", c, m0_gnt, m1_gnt, mem_ena, nxt_v && nxt_who == 0, nxt_v && nxt_who == 1, nxt_v); end
         if (nxt_v) begin
            n_chk++; if (mem_rw !== w[nxt_who] || mem_addr !== a[nxt_who]) begin n_err++; $display("FAIL rnd_port c=%0d: got rw=%b addr=%h want %b %h", c, mem_rw, mem_addr, w[nxt_who], a[nxt_who]); end
            if (w[nxt_who]) begin
               n_chk++; if (mem_wdata !== d[nxt_who]) begin n_err++; $display("FAIL rnd_wdata c=%0d: got %h want %h", c, mem_wdata, d[nxt_who]); end
            end
            last = nxt_who;
            idx  = int'(a[nxt_who] >> 2) - 32'h40;
            if (w[nxt_who]) ref_mem[idx] = d[nxt_who];
            else iss_rd = ref_mem[idx];
            iss_we  = w[nxt_who];
            iss_who = nxt_who;
            p[nxt_who] = 1'b0;
         end
         iss_v = nxt_v;
         for (int m = 0; m < 2; m++) begin
            if (!p[m] && $urandom_range(1, 0) == 1) begin
               p[m] = 1'b1;
               w[m] = 1'($urandom_range(1, 0));
               a[m] = 18'((32'h40 + $urandom_range(15, 0)) << 2);
               d[m] = $urandom;
            end
         end
      end
      m0_req = 1'b0; m1_req = 1'b0;
      step(); step();
      for (int i = 0; i < 16; i++) begin
         n_chk++; if (mem[32'h40 + i] !== ref_mem[i]) begin n_err++; $display("FAIL rnd_mem[%0d]: got %h want %h", i, mem[32'h40 + i], ref_mem[i]); end
      end
   endtask

   initial begin
      m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
      m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
      test_reset();
      test_single_write();
      test_contention();
      test_read_latency();
      test_late_request();
      test_reset_mid_issue();
`ifdef DMEM_ARB_ALIGN_CHK_EN
      test_align_err();
`else
      test_misaligned_pass();
`endif
      test_random();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end

endmodule
